// File: rtl/crg_result_reader_pkg.sv
// Shared types and sizing for the result reader.
// Holds the default RAM word / address / byte widths, the number of bytes
// per RAM word, and the readout FSM state encoding.
package crg_result_reader_pkg;

  localparam int WORD_W         = 256;
  localparam int ADDR_W         = 8;
  localparam int BYTE_W         = 8;
  localparam int BYTES_PER_WORD = WORD_W / BYTE_W;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RD_REQ  = 3'd1,
    RD_WAIT = 3'd2,
    SEND    = 3'd3,
    FINISH  = 3'd4
  } state_t;

endpackage

// File: rtl/crg_result_reader_if.sv
// Bundle of the readout request, result-RAM read port, UART byte handshake
// and status signals of crg_result_reader.
//   master : the reader (drives ram_addr, tx_data, tx_valid, busy, done)
//   slave  : its environment (drives start, first_addr, num_words,
//            ram_rdata, tx_ready)
interface crg_result_reader_if #(
  parameter int WORD_W = crg_result_reader_pkg::WORD_W,
  parameter int ADDR_W = crg_result_reader_pkg::ADDR_W,
  parameter int BYTE_W = crg_result_reader_pkg::BYTE_W
);

  logic              start;
  logic [ADDR_W-1:0] first_addr;
  logic [ADDR_W:0]   num_words;
  logic [ADDR_W-1:0] ram_addr;
  logic [WORD_W-1:0] ram_rdata;
  logic [BYTE_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic              busy;
  logic              done;

  modport master (
    input  start, first_addr, num_words, ram_rdata, tx_ready,
    output ram_addr, tx_data, tx_valid, busy, done
  );

  modport slave (
    output start, first_addr, num_words, ram_rdata, tx_ready,
    input  ram_addr, tx_data, tx_valid, busy, done
  );

endinterface

// File: rtl/crg_word_serializer.sv
// Byte shifter: captures one RAM word and presents it one byte at a time,
// least-significant byte first.
//   clk, rst_n : clock, synchronous active-low reset
//   load       : capture word and restart the byte count
//   word       : RAM word to serialise
//   shift      : current byte accepted, advance to the next one
//   byte_out   : byte currently on offer
//   last       : byte_out is the final byte of the word
module crg_word_serializer #(
  parameter int WORD_W = crg_result_reader_pkg::WORD_W,
  parameter int BYTE_W = crg_result_reader_pkg::BYTE_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [WORD_W-1:0] word,
  input  logic              shift,
  output logic [BYTE_W-1:0] byte_out,
  output logic              last
);

  localparam int NBYTES = WORD_W / BYTE_W;
  localparam int CNT_W  = $clog2(NBYTES);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(NBYTES - 1);

  logic [WORD_W-1:0] sreg;
  logic [CNT_W-1:0]  cnt;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sreg <= '0;
      cnt  <= '0;
    end else if (load) begin
      sreg <= word;
      cnt  <= '0;
    end else if (shift) begin
      sreg <= sreg >> BYTE_W;
      cnt  <= cnt + CNT_ONE;
    end
  end

  assign byte_out = sreg[BYTE_W-1:0];
  assign last     = (cnt == CNT_LAST);

endmodule

// File: rtl/crg_result_reader.sv
// Reads num_words consecutive words from the result RAM, starting at
// first_addr (wrapping modulo 2^ADDR_W), and streams every word to the UART
// transmitter byte by byte, least-significant byte first.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : request, RAM read port, byte handshake, busy/done status
module crg_result_reader #(
  parameter int WORD_W = crg_result_reader_pkg::WORD_W,
  parameter int ADDR_W = crg_result_reader_pkg::ADDR_W,
  parameter int BYTE_W = crg_result_reader_pkg::BYTE_W
) (
  input  logic                clk,
  input  logic                rst_n,
  crg_result_reader_if.master bus
);

  import crg_result_reader_pkg::*;

  localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);
  localparam logic [ADDR_W:0]   REM_ONE  = (ADDR_W + 1)'(1);

  state_t            state, state_nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W:0]   remaining;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [ADDR_W-1:0] addr_inc;
  logic [BYTE_W-1:0] ser_byte;
  logic              ser_last;
  logic              accept;
  logic              word_done;
  logic              more_words;

  assign accept     = (state == SEND) && bus.tx_ready;
  assign word_done  = accept && ser_last;
  assign more_words = (remaining > REM_ONE);
  assign addr_inc   = addr + ADDR_ONE;

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (bus.start) begin
          state_nxt = (bus.num_words == '0) ? FINISH : RD_REQ;
        end
      end
      RD_REQ:  state_nxt = RD_WAIT;
      RD_WAIT: state_nxt = SEND;
      SEND: begin
        if (word_done) begin
          state_nxt = more_words ? RD_REQ : FINISH;
        end
      end
      FINISH:  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // ram_addr is loaded on the edge that enters RD_REQ so the RAM sees the
  // address during RD_REQ and returns data for the RD_WAIT->SEND edge.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      ram_addr_q <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.start) begin
        addr      <= bus.first_addr;
        remaining <= bus.num_words;
        if (bus.num_words != '0) begin
          ram_addr_q <= bus.first_addr;
        end
      end
      if (word_done) begin
        addr      <= addr_inc;
        remaining <= remaining - REM_ONE;
        if (more_words) begin
          ram_addr_q <= addr_inc;
        end
      end
    end
  end

  crg_word_serializer #(
    .WORD_W (WORD_W),
    .BYTE_W (BYTE_W)
  ) u_ser (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (state == RD_WAIT),
    .word     (bus.ram_rdata),
    .shift    (accept),
    .byte_out (ser_byte),
    .last     (ser_last)
  );

  assign bus.ram_addr = ram_addr_q;
  assign bus.tx_data  = ser_byte;
  assign bus.tx_valid = (state == SEND);
  assign bus.busy     = (state == RD_REQ) || (state == RD_WAIT) || (state == SEND);
  assign bus.done     = (state == FINISH);

endmodule

// File: tb/tb_crg_result_reader.sv
// Testbench for crg_result_reader: random RAM contents, random/patterned
// tx_ready, expected byte stream built from the RAM image and the
// first_addr/num_words of each request.
module tb_crg_result_reader;

  localparam int BPW = crg_result_reader_pkg::BYTES_PER_WORD;

  logic clk;
  logic rst_n;

  crg_result_reader_if bus ();

  crg_result_reader dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [255:0] ram_mem [0:255];

  always @(posedge clk) bus.ram_rdata <= ram_mem[bus.ram_addr];

  int checks;
  int passed;

  logic [7:0] got_q  [$];
  logic [7:0] exp_q  [$];
  logic [7:0] addr_q [$];
  int         gap_q  [$];
  int first_valid_n, done_n, last_acc_n, valid_cnt;
  int hold_err, busy_err;
  bit timed_out, reset_hit;
  logic done_after, busy_after;
  logic [7:0] ram_addr_after;

  task automatic fill_ram();
    for (int a = 0; a < 256; a++)
      for (int j = 0; j < 8; j++)
        ram_mem[a][j*32 +: 32] = $urandom;
  endtask

  function automatic void build_exp(input logic [7:0] fa, input int nw);
    exp_q.delete();
    for (int w = 0; w < nw; w++)
      for (int k = 0; k < BPW; k++)
        exp_q.push_back(ram_mem[(int'(fa) + w) % 256][k*8 +: 8]);
  endfunction

  function automatic int count_diff();
    int n;
    n = 0;
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
      if (got_q[i] !== exp_q[i]) n++;
    return n;
  endfunction

  // Issues one request and records what the DUT does, cycle by cycle.
  // mode: 0 ready always, 1 ready toggles, 2 ready random.
  task automatic run_xfer(input logic [7:0] fa, input logic [8:0] nw, input int mode,
                          input int restart_at, input int reset_at);
    int   limit, gap;
    bit   prev_v, prev_r, rec_next, in_gap, r;
    logic [7:0] prev_d;
    got_q.delete(); addr_q.delete(); gap_q.delete();
    first_valid_n = -1; done_n = -1; last_acc_n = -1; valid_cnt = 0;
    hold_err = 0; busy_err = 0; timed_out = 0; reset_hit = 0;
    limit = (int'(nw) + 1) * 160 + 50;
    prev_v = 0; prev_r = 0; prev_d = '0; rec_next = 0; in_gap = 0; gap = 0;
    bus.first_addr = fa;
    bus.num_words  = nw;
    bus.start      = 1'b1;
    for (int n = 1; n <= limit; n++) begin
      @(negedge clk);
      if (n == 1 || n == restart_at + 1) bus.start = 1'b0;
      if (n == restart_at) begin
        bus.start      = 1'b1;
        bus.first_addr = fa + 8'd77;
        bus.num_words  = 9'd1;
      end
      if ((n == 1 || rec_next) && bus.busy) addr_q.push_back(bus.ram_addr);
      rec_next = 0;
      if (bus.tx_valid) begin
        valid_cnt++;
        if (first_valid_n < 0) first_valid_n = n;
      end
      if (in_gap) begin
        if (bus.tx_valid) begin
          gap_q.push_back(gap);
          in_gap = 0;
        end else gap++;
      end
      if (prev_v && !prev_r && !(bus.tx_valid && bus.tx_data == prev_d)) hold_err++;
      if (bus.done) begin
        done_n = n;
        break;
      end
      if (!bus.busy) busy_err++;
      if (reset_at >= 0 && got_q.size() == reset_at) begin
        rst_n = 1'b0;
        reset_hit = 1;
        break;
      end
      case (mode)
        0:       r = 1'b1;
        1:       r = (n % 2) == 1;
        default: r = 1'($urandom_range(0, 1));
      endcase
      bus.tx_ready = r;
      if (bus.tx_valid && r) begin
        got_q.push_back(bus.tx_data);
        last_acc_n = n;
        if (got_q.size() % BPW == 0) begin
          rec_next = 1;
          in_gap   = 1;
          gap      = 0;
        end
      end
      prev_v = bus.tx_valid;
      prev_r = r;
      prev_d = bus.tx_data;
    end
    if (done_n < 0 && !reset_hit) timed_out = 1;
    bus.tx_ready = 1'b0;
    bus.start    = 1'b0;
    if (!reset_hit) begin
      @(negedge clk);
      done_after     = bus.done;
      busy_after     = bus.busy;
      ram_addr_after = bus.ram_addr;
    end
  endtask

  task automatic test_reset();
    checks++; if (bus.tx_valid !== 1'b0) $display("FAIL reset_tx_valid: got %0b expected 0", bus.tx_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL reset_busy: got %0b expected 0", bus.busy); else passed++;
    checks++; if (bus.done !== 1'b0) $display("FAIL reset_done: got %0b expected 0", bus.done); else passed++;
    checks++; if (bus.ram_addr !== 8'd0) $display("FAIL reset_ram_addr: got %0d expected 0", bus.ram_addr); else passed++;
  endtask

  task automatic test_single_word();
    int nd;
    for (int k = 0; k < BPW; k++) ram_mem[0][k*8 +: 8] = 8'(k);
    run_xfer(8'd0, 9'd1, 0, -1, -1);
    checks++; if (timed_out !== 1'b0) $display("FAIL single_timeout: got %0b expected 0", timed_out); else passed++;
    checks++; if (got_q.size() !== 32) $display("FAIL single_count: got %0d expected 32", got_q.size()); else passed++;
    nd = 0;
    for (int k = 0; k < got_q.size(); k++) if (got_q[k] !== 8'(k)) nd++;
    checks++; if (nd !== 0) $display("FAIL single_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    checks++; if (first_valid_n !== 3) $display("FAIL single_latency: got %0d expected 3", first_valid_n); else passed++;
    checks++; if (done_n !== last_acc_n + 1) $display("FAIL single_done_time: got %0d expected %0d", done_n, last_acc_n + 1); else passed++;
    checks++; if (done_after !== 1'b0) $display("FAIL single_done_width: got %0b expected 0", done_after); else passed++;
    checks++; if (busy_after !== 1'b0) $display("FAIL single_busy_after: got %0b expected 0", busy_after); else passed++;
  endtask

  task automatic test_wrap();
    int nd;
    fill_ram();
    build_exp(8'd254, 3);
    run_xfer(8'd254, 9'd3, 0, -1, -1);
    checks++; if (got_q.size() !== 96) $display("FAIL wrap_count: got %0d expected 96", got_q.size()); else passed++;
    nd = count_diff();
    checks++; if (nd !== 0) $display("FAIL wrap_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    checks++; if (addr_q.size() !== 3) $display("FAIL wrap_addr_count: got %0d expected 3", addr_q.size()); else passed++;
    nd = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 8'((254 + i) % 256)) nd++;
    checks++; if (nd !== 0) $display("FAIL wrap_addr_seq: got %0d wrong addresses expected 0", nd); else passed++;
    checks++; if (busy_err !== 0) $display("FAIL wrap_busy: got %0d low cycles expected 0", busy_err); else passed++;
    nd = 0;
    for (int i = 0; i < gap_q.size(); i++) if (gap_q[i] !== 2) nd++;
    checks++; if (gap_q.size() !== 2 || nd !== 0) $display("FAIL wrap_gap: got %0d gaps (%0d not 2) expected 2 gaps of 2", gap_q.size(), nd); else passed++;
  endtask

  task automatic test_backpressure();
    int nd;
    logic [7:0] fa;
    fill_ram();
    fa = 8'($urandom);
    build_exp(fa, 2);
    run_xfer(fa, 9'd2, 1, -1, -1);
    checks++; if (timed_out !== 1'b0) $display("FAIL toggle_timeout: got %0b expected 0", timed_out); else passed++;
    checks++; if (got_q.size() !== 64) $display("FAIL toggle_count: got %0d expected 64", got_q.size()); else passed++;
    nd = count_diff();
    checks++; if (nd !== 0) $display("FAIL toggle_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    checks++; if (hold_err !== 0) $display("FAIL toggle_hold: got %0d violations expected 0", hold_err); else passed++;
  endtask

  task automatic test_random_ready();
    int nd, nw;
    logic [7:0] fa;
    for (int it = 0; it < 3; it++) begin
      fill_ram();
      fa = 8'($urandom);
      nw = $urandom_range(1, 4);
      build_exp(fa, nw);
      run_xfer(fa, 9'(nw), 2, -1, -1);
      checks++; if (got_q.size() !== exp_q.size()) $display("FAIL rand_count: got %0d expected %0d", got_q.size(), exp_q.size()); else passed++;
      nd = count_diff();
      checks++; if (nd !== 0) $display("FAIL rand_bytes: got %0d wrong bytes expected 0", nd); else passed++;
      checks++; if (hold_err !== 0) $display("FAIL rand_hold: got %0d violations expected 0", hold_err); else passed++;
    end
  endtask

  task automatic test_zero_len();
    logic [7:0] addr_before;
    addr_before = bus.ram_addr;
    run_xfer(8'd99, 9'd0, 0, -1, -1);
    checks++; if (done_n !== 1) $display("FAIL zero_done_time: got %0d expected 1", done_n); else passed++;
    checks++; if (valid_cnt !== 0) $display("FAIL zero_tx_valid: got %0d cycles expected 0", valid_cnt); else passed++;
    checks++; if (ram_addr_after !== addr_before) $display("FAIL zero_ram_addr: got %0d expected %0d", ram_addr_after, addr_before); else passed++;
    checks++; if (addr_q.size() !== 0) $display("FAIL zero_busy: got %0d busy samples expected 0", addr_q.size()); else passed++;
  endtask

  task automatic test_reset_mid();
    int nd;
    fill_ram();
    run_xfer(8'd10, 9'd3, 0, -1, 42);
    checks++; if (reset_hit !== 1'b1) $display("FAIL midrst_reached: got %0b expected 1", reset_hit); else passed++;
    @(negedge clk);
    checks++; if (bus.tx_valid !== 1'b0) $display("FAIL midrst_tx_valid: got %0b expected 0", bus.tx_valid); else passed++;
    checks++; if (bus.busy !== 1'b0) $display("FAIL midrst_busy: got %0b expected 0", bus.busy); else passed++;
    rst_n = 1'b1;
    @(negedge clk);
    build_exp(8'd5, 1);
    run_xfer(8'd5, 9'd1, 0, -1, -1);
    checks++; if (got_q.size() !== 32) $display("FAIL midrst_count: got %0d expected 32", got_q.size()); else passed++;
    nd = count_diff();
    checks++; if (nd !== 0) $display("FAIL midrst_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    checks++; if (first_valid_n !== 3) $display("FAIL midrst_latency: got %0d expected 3", first_valid_n); else passed++;
  endtask

  task automatic test_start_ignored();
    int nd;
    logic [7:0] fa;
    fill_ram();
    fa = 8'($urandom);
    build_exp(fa, 2);
    run_xfer(fa, 9'd2, 0, 20, -1);
    checks++; if (got_q.size() !== 64) $display("FAIL restart_count: got %0d expected 64", got_q.size()); else passed++;
    nd = count_diff();
    checks++; if (nd !== 0) $display("FAIL restart_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    checks++; if (addr_q.size() !== 2 || addr_q[1] !== fa + 8'd1) $display("FAIL restart_addr: got %0d addresses expected 2", addr_q.size()); else passed++;
  endtask

  task automatic test_back_to_back();
    int nd;
    logic [7:0] fa;
    fill_ram();
    fa = 8'($urandom);
    build_exp(fa, 256);
    run_xfer(fa, 9'd256, 0, -1, -1);
    checks++; if (got_q.size() !== 8192) $display("FAIL full_count: got %0d expected 8192", got_q.size()); else passed++;
    nd = count_diff();
    checks++; if (nd !== 0) $display("FAIL full_bytes: got %0d wrong bytes expected 0", nd); else passed++;
    nd = 0;
    for (int i = 0; i < addr_q.size(); i++) if (addr_q[i] !== 8'((int'(fa) + i) % 256)) nd++;
    checks++; if (addr_q.size() !== 256 || nd !== 0) $display("FAIL full_addr_seq: got %0d addresses (%0d wrong) expected 256", addr_q.size(), nd); else passed++;
    checks++; if (first_valid_n !== 3) $display("FAIL full_latency: got %0d expected 3", first_valid_n); else passed++;
  endtask

  initial begin
    checks = 0;
    passed = 0;
    rst_n = 1'b0;
    bus.start = 1'b0;
    bus.first_addr = '0;
    bus.num_words = '0;
    bus.tx_ready = 1'b0;
    for (int a = 0; a < 256; a++) ram_mem[a] = '0;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    test_single_word();
    test_wrap();
    test_backpressure();
    test_random_ready();
    test_zero_len();
    test_reset_mid();
    test_start_ignored();
    test_back_to_back();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
